// File: rtl/ahb_slave_mem.sv
// AHB responder backed by a word-addressed memory, with programmable wait states
// and two-cycle ERROR responses for bad addresses and sizes.
module ahb_slave_mem #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP
);

  localparam int unsigned AW      = $clog2(MEM_WORDS);
  localparam logic [32:0] Span    = 33'(4 * MEM_WORDS);
  localparam logic [2:0]  LastCnt = 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic            write_q, write_d;
  logic [31:0]     mem [MEM_WORDS];

  logic [32:0]     offset;
  logic            addr_err, size_err;
  logic [3:0]      byte_en;

  // Burst type and the BUSY/IDLE distinction carry no meaning here.
  logic unused_sig;
  assign unused_sig = ^{HBURST, HTRANS[0]};

  // Address-phase error decode; the 33-bit borrow flags addresses below the base.
  always_comb begin
    offset   = {1'b0, HADDR} - {1'b0, ADDR_BASE};
    addr_err = offset[32] || (offset >= Span);
    size_err = (HSIZE > 3'd2) ||
               ((HSIZE == 3'd1) && HADDR[0]) ||
               ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    HREADY  = 1'b1;
    HRESP   = 2'b00;
    unique case (state_q)
      StWait: begin
        HREADY = 1'b0;
        if (cnt_q == LastCnt) begin
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StErr1: begin
        HREADY  = 1'b0;
        HRESP   = 2'b01;
        state_d = StErr2;
      end
      StIdle, StData, StErr2: begin
        if (state_q == StErr2) HRESP = 2'b01;
        if (HTRANS[1]) begin
          addr_d  = offset[AW+1:0];
          size_d  = HSIZE;
          write_d = HWRITE;
          cnt_d   = 3'd0;
          if (addr_err || size_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES > 0) begin
            state_d = StWait;
          end else begin
            state_d = StData;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and captured address-phase registers.
  always_ff @(posedge clk or negedge HRESET) begin
    if (!HRESET) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  // Little-endian byte lanes touched by the stored transfer.
  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'd0:    byte_en[addr_q[1:0]] = 1'b1;
      3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Write commits at the edge that ends the DATA phase; contents survive reset.
  always_ff @(posedge clk) begin
    if ((state_q == StData) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Read data only during a read DATA cycle, zero otherwise.
  always_comb begin
    HRDATA = 32'h0;
    if ((state_q == StData) && !write_q) HRDATA = mem[addr_q[AW+1:2]];
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB responder with a word-addressed internal memory. It is the slave end of the team's AHB interface: it samples the master-driven address/control/write-data signals and drives HREADY, HRESP and HRDATA back. It is the single slave on the bus, so there is no HSEL and it is always selected. It provides a programmable number of wait states and ERROR responses for verifying master and bus-monitor components.

## Interface
- MEM_WORDS, 256: memory depth in 32-bit words (power of two, 4..4096)
- ADDR_BASE, 32'h0000_0000: byte address of word 0 (aligned to 4*MEM_WORDS)
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase (0..7)

- clk  input  1  bus clock, all logic on rising edge
- HRESET  input  1  asynchronous, active-low reset
- HADDR  input  32  byte address (address phase)
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HBURST  input  3  burst type; accepted but not used (master supplies every address)
- HSIZE  input  3  000 byte, 001 halfword, 010 word
- HWRITE  input  1  1 write, 0 read
- HWDATA  input  32  write data (data phase)
- HREADY  output  1  transfer complete / slave ready
- HRDATA  output  32  read data (data phase)
- HRESP  output  2  00 OKAY, 01 ERROR (RETRY/SPLIT never issued)

## Operation
- Address phase is accepted on a rising edge where HREADY=1 and HTRANS is NONSEQ or SEQ.
  - On acceptance, register HADDR, HSIZE and HWRITE.
  - Decide the response at the same edge.
- IDLE/BUSY accepted with HREADY=1: the next cycle is a zero-wait OKAY with no memory access.
- ERROR conditions, checked in the address phase:
  - HADDR < ADDR_BASE or HADDR >= ADDR_BASE+4*MEM_WORDS
  - HSIZE > 010
  - HSIZE=001 with HADDR[0]=1
  - HSIZE=010 with HADDR[1:0]!=00
- States:
  - IDLE: HREADY=1, HRESP=00.
  - WAIT: HREADY=0, HRESP=00. A counter runs 0..WAIT_STATES-1 and the FSM goes to DATA when it expires.
  - DATA: HREADY=1, HRESP=00. Read data is driven; write data is sampled.
  - ERR1: HREADY=0, HRESP=01.
  - ERR2: HREADY=1, HRESP=01.
- Transitions:
  - Accepted valid transfer: to WAIT if WAIT_STATES>0, else to DATA.
  - Accepted erroneous transfer: to ERR1, then always to ERR2 (errors get no wait states).
  - From DATA or ERR2 (HREADY=1): accept the next address phase as from IDLE, or go to IDLE on IDLE/BUSY.
- Write: at the edge ending DATA, write the byte lanes selected by HSIZE and the stored HADDR[1:0] (little-endian) from the matching HWDATA lanes. Other bytes are unchanged. An ERROR transfer never writes.
- Read: in DATA, HRDATA is the full 32-bit word at the stored address. All lanes are driven regardless of HSIZE.
- HRDATA=0 whenever the FSM is not in a read DATA cycle.
- A read data phase immediately after a write data phase to the same word returns the newly written data, because the write commits at the edge that starts the read data phase.
- Memory contents are not reset.

## Timing
- Reset (HRESET=0) forces, asynchronously: HREADY=1, HRESP=00, HRDATA=0, state IDLE, wait counter 0.
- Reset mid-transfer aborts the transfer; a pending write is discarded.
- The first address phase may be accepted on the first rising edge after reset deassertion.
- Latency, address-phase edge to data-phase completion edge: 1+WAIT_STATES cycles for OKAY, 2 cycles for ERROR.
- Pipelining: the next address phase overlaps the current data phase. It is sampled only on the edge where HREADY=1.
- During wait cycles, changes on HADDR/HTRANS are ignored and HWDATA must be held stable by the master. The slave samples HWDATA only on the final DATA edge.
- HTRANS transitions back to back (SEQ after SEQ) with WAIT_STATES=0 sustain one transfer per cycle.

## Test plan
- Word write then read, WAIT_STATES=0:
  - Stimulus: NONSEQ write 0x10 data 0xDEADBEEF, then NONSEQ read 0x10.
  - Response: HREADY stays 1, read data phase HRDATA=0xDEADBEEF, HRESP=00.
- Byte/halfword lanes:
  - Stimulus: word 0x20 = 0x11223344; byte write 0x21 data 0x0000AA00; halfword write 0x22 data 0x55660000.
  - Response: read 0x20 returns 0x5566AA44.
- Wait states, WAIT_STATES=3:
  - Stimulus: INCR4 reads 0x40..0x4C.
  - Response: each data phase shows HREADY low for exactly 3 cycles; the addresses following in the pipeline are held; all four words are correct.
- ERROR, with a one-cycle write at 0x8 for the pipelined transfer:
  - Stimulus: write to 0x400 with MEM_WORDS=256; separately, word read at 0x2.
  - Response: each gets HREADY=0/HRESP=01, then HREADY=1/HRESP=01, and no memory change; the pipelined write at 0x8 still completes.
- IDLE/BUSY interleaved in an INCR burst:
  - Stimulus: NONSEQ, BUSY, SEQ.
  - Response: the BUSY data phase is a zero-wait OKAY with no write; the SEQ write lands.
- Reset mid-transfer, WAIT_STATES=2:
  - Stimulus: assert HRESET during the wait cycle of a write to 0x30.
  - Response: outputs immediately HREADY=1, HRESP=00, HRDATA=0; word 0x30 is unchanged.
